mult_result_collector: RTL and testbench

MULT_RESULT_COLLECTOR -- requirements
Module: mult_result_collector

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_result_collector_if.sv | 28 ++
 rtl/mult_res_fifo.sv | 54 +++++
 rtl/mult_result_collector.sv | 72 +++++++
 tb/tb_mult_result_collector.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared widths and defaults for the multiplier result collector.
// Also holds the saturating increment used by the drop counter.
package mult_pkg;

  localparam int PROD_W        = 8;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_SUM_W = 12;
  localparam int DROP_W        = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (value == DROP_MAX) ? value : value + DROP_W'(1);
  endfunction

endpackage

// File: rtl/mult_result_collector_if.sv
// Product capture and result streaming signals of the collector.
// The slave side belongs to the collector, the master side to its environment.
interface mult_result_collector_if;
  import mult_pkg::*;

  logic [PROD_W-1:0] product;
  logic              op_ready;
  logic [PROD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output product,
    output op_ready,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  product,
    input  op_ready,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/mult_res_fifo.sv
// Power-of-two result FIFO: storage, wrapping pointers and occupancy.
// A write while full is accepted only when a read frees the head slot in the same cycle.
module mult_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; writes are still suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mult_result_collector.sv
// Captures one product per op_ready rising edge into a FIFO, keeping a running
// sum with sticky wrap flag and a saturating count of products lost to a full FIFO.
module mult_result_collector
  import mult_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SUM_W = DEFAULT_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  mult_result_collector_if.slave  bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic [SUM_W-1:0]        sum,
  output logic                    sum_ovf,
  output logic [DROP_W-1:0]       drop_cnt
);

  logic             op_ready_q;
  logic             capture;
  logic             pop;
  logic             dropped;
  logic             empty;
  logic [SUM_W:0]   sum_ext;

  assign capture = bus.op_ready && !op_ready_q;
  assign pop     = !empty && bus.out_ready;
  assign dropped = capture && full && !pop;
  assign sum_ext = {1'b0, sum} + (SUM_W+1)'(bus.product);

  assign bus.out_valid = !empty;

  mult_res_fifo #(
    .DEPTH (DEPTH),
    .W     (PROD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (bus.product),
    .rd_en   (bus.out_ready),
    .rd_data (bus.out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Every capture feeds the sum, even one the FIFO had to drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_ready_q <= 1'b0;
      sum        <= '0;
      sum_ovf    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      op_ready_q <= bus.op_ready;
      if (clr) begin
        sum      <= capture ? SUM_W'(bus.product) : '0;
        sum_ovf  <= 1'b0;
        drop_cnt <= dropped ? DROP_W'(1) : '0;
      end else begin
        if (capture) begin
          sum <= sum_ext[SUM_W-1:0];
          if (sum_ext[SUM_W]) sum_ovf <= 1'b1;
        end
        if (dropped) drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mult_result_collector.sv
// Randomized and directed bench for mult_result_collector with a queue-based
// reference model; a negedge monitor pops expected products and checks state.
module tb_mult_result_collector;
  import mult_pkg::*;

  localparam int DEPTH = 4;
  localparam int SUM_W = 12;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int QSZ   = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [CW-1:0]     count;
  logic              full;
  logic [SUM_W-1:0]  sum;
  logic              sum_ovf;
  logic [DROP_W-1:0] drop_cnt;

  mult_result_collector_if bus();

  mult_result_collector #(
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .sum      (sum),
    .sum_ovf  (sum_ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_mem [QSZ];
  int exp_wr = 0;
  int exp_rd = 0;
  int m_sum  = 0;
  bit m_ovf  = 1'b0;
  int m_drop = 0;
  bit m_prev = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [7:0] prod, input logic ordy, input logic c);
    bus.op_ready  = op;
    bus.product   = prod;
    bus.out_ready = ordy;
    clr           = c;
    @(posedge clk);
    #1;
  endtask

  task automatic capturePulse(input logic [7:0] prod, input logic ordy);
    applyStimulus(1'b1, prod, ordy, 1'b0);
    applyStimulus(1'b0, 8'h00, ordy, 1'b0);
  endtask

  // Reference model: a queue of accepted products plus arithmetic on the sum.
  always @(posedge clk) begin
    bit cap;
    bit dropped;
    if (!rst_n) begin
      exp_wr = exp_rd;
      m_sum  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_prev = 1'b0;
    end else begin
      cap     = bus.op_ready && !m_prev;
      m_prev  = bus.op_ready;
      dropped = 1'b0;
      if (cap) begin
        if (exp_wr - exp_rd < DEPTH) begin
          exp_mem[exp_wr % QSZ] = bus.product;
          exp_wr++;
        end else begin
          dropped = 1'b1;
        end
      end
      if (clr) begin
        m_sum  = cap ? int'(bus.product) : 0;
        m_ovf  = 1'b0;
        m_drop = dropped ? 1 : 0;
      end else begin
        if (cap) begin
          m_sum = m_sum + int'(bus.product);
          if (m_sum >= (1 << SUM_W)) begin
            m_sum = m_sum - (1 << SUM_W);
            m_ovf = 1'b1;
          end
        end
        if (dropped && m_drop < 255) m_drop++;
      end
    end
  end

  always @(negedge clk) begin
    int occ;
    occ = exp_wr - exp_rd;
    checkOutput("count", 32'(count), 32'(occ));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(occ != 0));
    checkOutput("full", 32'(full), 32'(occ == DEPTH));
    checkOutput("sum", 32'(sum), 32'(m_sum));
    checkOutput("sum_ovf", 32'(sum_ovf), 32'(m_ovf));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (occ > 0 && bus.out_ready) begin
      checkOutput("out_data", 32'(bus.out_data), 32'(exp_mem[exp_rd % QSZ]));
      exp_rd++;
    end
  end

  initial begin
    int thr;
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h2D, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h2D, 1'b0, 1'b0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);

    // op_ready held high through reset release gives a single capture.
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b1, 8'h2D, 1'b0, 1'b0);
    checkOutput("held_count", 32'(count), 32'd1);
    checkOutput("held_data", 32'(bus.out_data), 32'h2D);
    checkOutput("held_sum", 32'(sum), 32'd45);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_sum", 32'(sum), 32'd0);

    for (int p = 1; p <= 5; p++) capturePulse(8'(p), 1'b0);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_drop", 32'(drop_cnt), 32'd1);
    checkOutput("fill_sum", 32'(sum), 32'd15);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_order", 32'(bus.out_data), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(bus.out_valid), 32'd0);

    // Capture against a full FIFO while popping.
    for (int p = 1; p <= 4; p++) capturePulse(8'(p), 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("swap_count", 32'(count), 32'd4);
    checkOutput("swap_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("swap_order", 32'(bus.out_data), (i == 3) ? 32'h07 : 32'(i + 2));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // clr coinciding with a dropped capture.
    for (int p = 1; p <= 4; p++) capturePulse(8'(p), 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clrcap_sum", 32'(sum), 32'h33);
    checkOutput("clrcap_drop", 32'(drop_cnt), 32'd1);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (16) capturePulse(8'hFF, 1'b1);
    checkOutput("wrap_sum_pre", 32'(sum), 32'd4080);
    checkOutput("wrap_ovf_pre", 32'(sum_ovf), 32'd0);
    capturePulse(8'h20, 1'b1);
    checkOutput("wrap_sum", 32'(sum), 32'd16);
    checkOutput("wrap_ovf", 32'(sum_ovf), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("wrap_clr_sum", 32'(sum), 32'd0);
    checkOutput("wrap_clr_ovf", 32'(sum_ovf), 32'd0);

    // Drop counter saturation.
    for (int p = 0; p < 4 + 260; p++) capturePulse(8'(p), 1'b0);
    checkOutput("drop_sat", 32'(drop_cnt), 32'd255);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    for (int p = 0; p < 3; p++) capturePulse(8'(p + 9), 1'b0);
    checkOutput("prerst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);

    for (int c = 0; c < 10000; c++) begin
      thr   = (c < 5000) ? 3 : 7;
      rst_n = ($urandom_range(0, 999) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 9) < thr), 1'($urandom_range(0, 99) == 0));
    end
    rst_n = 1'b1;
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
